fifo_regfile_ctrl: RTL and testbench
====================================

// Module: fifo_regfile_ctrl
// PURPOSE
//  Parametrised FIFO built on a register file: write-side storage, read-side mux, head/tail pointers, occupancy counter.
//  Generalises the fixed 8x32 register-file read mux to DEPTH x WIDTH, adding write, pointers and status.
//  Buffers operands between the factorial datapath and its bus interface.
//  Reports ack/error status every cycle.
// PARAMETERS
//  WIDTH  32  data word width in bits
//  DEPTH  8   number of entries; power of two, >= 2
//  AW     3   pointer width = log2(DEPTH); must match DEPTH
// PORTS
//  clk         in   1        single clock, all state updates on rising edge
//  reset_n     in   1        synchronous, active-low reset
//  wr_en       in   1        write request, sampled at rising edge
//  rd_en       in   1        read request, sampled at rising edge
//  d_in        in   WIDTH    write data
//  d_out       out  WIDTH    registered read data
//  full        out  1        data_count == DEPTH
//  empty       out  1        data_count == 0
//  wr_ack      out  1        write accepted in the last cycle
//  wr_err      out  1        write rejected (FIFO full)
//  rd_ack      out  1        read accepted; d_out valid
//  rd_err      out  1        read rejected (FIFO empty)
//  data_count  out  AW+1     current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset: reset_n==0 at clk edge ->
//   - state INIT
//   - head=tail=0, data_count=0, d_out=0
//   - wr_ack=wr_err=rd_ack=rd_err=0
//   - empty=1, full=0
//   - memory contents not cleared
//  Reset overrides any request in the same cycle; mid-operation reset discards stored data (count forced to 0).
//  FSM states: INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR. Next state evaluated every edge from inputs and current count:
//   - wr_en=1, rd_en=0: WRITE if !full, else WR_ERROR
//   - rd_en=1, wr_en=0: READ if !empty, else RD_ERROR
//   - wr_en=rd_en (both 0 or both 1): NO_OP; simultaneous requests are ignored, no pointer or count change
//  Datapath, registered on the same edge the state is entered:
//   - WRITE: mem[tail]<=d_in; tail<=tail+1, wrapping DEPTH-1 -> 0; count+1
//   - READ: d_out<=mem[head]; head<=head+1, wrapping; count-1
//   - WR_ERROR, RD_ERROR, NO_OP, INIT: pointers, count, memory and d_out hold
//  Status outputs are registered and decoded one-hot from the new state; each is high for exactly one cycle per accepted or rejected request:
//   - wr_ack=1 only in WRITE; wr_err=1 only in WR_ERROR
//   - rd_ack=1 only in READ; rd_err=1 only in RD_ERROR
//  Latency: d_out and rd_ack valid 1 cycle after rd_en is sampled. A written word is readable on the next edge.
//  full and empty are combinational from data_count. They are never both 1.
//  Write when full never overwrites; read when empty never moves head. Count never exceeds DEPTH or drops below 0.
//  Ordering: strict first-in first-out across pointer wrap.
// TESTING
//  1) Reset: hold reset_n=0 two cycles with wr_en=1 -> count=0, empty=1, full=0, d_out=0, all acks/errs 0.
//  2) Fill/drain: write 1..8 (DEPTH=8) -> wr_ack each cycle, full=1 after 8th; read 8x -> d_out 1..8 in order, empty=1 at end.
//  3) Overflow/underflow: 9th write when full -> wr_err=1, count stays 8; read when empty -> rd_err=1, d_out holds last value.
//  4) Wrap: write 6, read 6, write 5 (0xA0..0xA4), read 5 -> data returned 0xA0..0xA4 across pointer wrap.
//  5) Simultaneous: wr_en=rd_en=1 with count=3 -> NO_OP, count stays 3, no ack/err asserted.
//  6) Mid-op reset: count=5, assert reset_n=0 one cycle -> count=0, empty=1; next read gives rd_err=1.

Source files
------------

// File: rtl/fifo_regfile_ctrl.sv
// DEPTH x WIDTH register-file FIFO with head/tail pointers, an occupancy counter and
// one-cycle ack/error status pulses, sitting between the factorial datapath and its bus.

module fifo_regfile_ctrl_chk #(
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input logic          clk,
    input logic          reset_n,
    input logic [2:0]    state,
    input logic          wr_ack,
    input logic          wr_err,
    input logic          rd_ack,
    input logic          rd_err,
    input logic          full,
    input logic          empty,
    input logic [AW:0]   data_count
);
    a_not_full_and_empty: assert property (@(posedge clk) disable iff (!reset_n)
        !(full && empty));

    a_count_in_range: assert property (@(posedge clk) disable iff (!reset_n)
        data_count <= (AW+1)'(DEPTH));

    // Status pulses must be an exact one-hot decode of the registered state.
    a_status_decode: assert property (@(posedge clk) disable iff (!reset_n)
        {wr_ack, wr_err, rd_ack, rd_err} ==
        {state == 3'd2, state == 3'd3, state == 3'd4, state == 3'd5});
endmodule

module fifo_regfile_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             full,
    output logic             empty,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             rd_ack,
    output logic             rd_err,
    output logic [AW:0]      data_count
);
    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_NO_OP    = 3'd1,
        ST_WRITE    = 3'd2,
        ST_WR_ERROR = 3'd3,
        ST_READ     = 3'd4,
        ST_RD_ERROR = 3'd5
    } state_t;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];

    state_t           state_q,  state_d;
    logic [AW-1:0]    head_q,   head_d;
    logic [AW-1:0]    tail_q,   tail_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] d_out_q,  d_out_d;
    logic             wr_ack_q, wr_ack_d;
    logic             wr_err_q, wr_err_d;
    logic             rd_ack_q, rd_ack_d;
    logic             rd_err_q, rd_err_d;
    logic             mem_we_s;
    logic             full_s;
    logic             empty_s;

    assign full_s  = (count_q == FULL_CNT);
    assign empty_s = (count_q == {(AW+1){1'b0}});

    // Next-state decode plus the datapath update for the state being entered.
    always_comb begin
        state_d  = ST_NO_OP;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        d_out_d  = d_out_q;
        mem_we_s = 1'b0;

        if (wr_en && !rd_en) begin
            if (full_s) begin
                state_d = ST_WR_ERROR;
            end else begin
                state_d = ST_WRITE;
            end
        end else if (rd_en && !wr_en) begin
            if (empty_s) begin
                state_d = ST_RD_ERROR;
            end else begin
                state_d = ST_READ;
            end
        end else begin
            state_d = ST_NO_OP;
        end

        // Pointers wrap naturally because DEPTH is a power of two.
        case (state_d)
            ST_WRITE: begin
                mem_we_s = 1'b1;
                tail_d   = tail_q + PTR_ONE;
                count_d  = count_q + CNT_ONE;
            end
            ST_READ: begin
                d_out_d  = mem_q[head_q];
                head_d   = head_q + PTR_ONE;
                count_d  = count_q - CNT_ONE;
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase

        wr_ack_d = (state_d == ST_WRITE);
        wr_err_d = (state_d == ST_WR_ERROR);
        rd_ack_d = (state_d == ST_READ);
        rd_err_d = (state_d == ST_RD_ERROR);
    end

    // Control state, pointers, count, read data and status flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            head_q   <= {AW{1'b0}};
            tail_q   <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            d_out_q  <= {WIDTH{1'b0}};
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            d_out_q  <= d_out_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage is deliberately left uncleared by reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we_s) begin
            mem_q[tail_q] <= d_in;
        end
    end

    assign d_out      = d_out_q;
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign rd_ack     = rd_ack_q;
    assign rd_err     = rd_err_q;
    assign data_count = count_q;
    assign full       = full_s;
    assign empty      = empty_s;

    fifo_regfile_ctrl_chk #(.AW(AW), .DEPTH(DEPTH)) u_chk (
        .clk        (clk),
        .reset_n    (reset_n),
        .state      (state_q),
        .wr_ack     (wr_ack_q),
        .wr_err     (wr_err_q),
        .rd_ack     (rd_ack_q),
        .rd_err     (rd_err_q),
        .full       (full_s),
        .empty      (empty_s),
        .data_count (count_q)
    );
endmodule

// File: tb/tb_fifo_regfile_ctrl.sv
// Scoreboard bench for fifo_regfile_ctrl (WIDTH=32, DEPTH=8): stimulus queues expected
// status/data, a negedge monitor pops and compares whenever a status pulse appears.

module tb_fifo_regfile_ctrl;
    localparam logic [3:0] ST_WACK = 4'b1000;
    localparam logic [3:0] ST_WERR = 4'b0100;
    localparam logic [3:0] ST_RACK = 4'b0010;
    localparam logic [3:0] ST_RERR = 4'b0001;

    typedef struct packed {
        logic [3:0]  st;
        logic [31:0] dout;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] d_in = 32'h0;
    logic [31:0] d_out;
    logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
    logic [3:0]  data_count;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic        mon_on = 1'b0;
    logic [31:0] last_rd = 32'h0;

    fifo_regfile_ctrl #(.WIDTH(32), .DEPTH(8), .AW(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .d_in       (d_in),
        .d_out      (d_out),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .data_count (data_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [31:0] d);
        wr_en = w;
        rd_en = r;
        d_in  = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic push(input logic [3:0] st, input logic [31:0] dout);
        exp_t e;
        e.st   = st;
        e.dout = dout;
        exp_q.push_back(e);
    endtask

    task automatic do_write(input logic [31:0] d, input logic [3:0] st);
        push(st, last_rd);
        step(1'b1, 1'b0, d);
    endtask

    task automatic do_read(input logic [31:0] d, input logic [3:0] st);
        if (st == ST_RACK) last_rd = d;
        push(st, last_rd);
        step(1'b0, 1'b1, 32'h0);
    endtask

    // Monitor: every status pulse must match the oldest queued expectation.
    initial begin
        logic [3:0] st;
        exp_t e;
        wait (mon_on);
        forever begin
            @(negedge clk);
            st = {wr_ack, wr_err, rd_ack, rd_err};
            if (st !== 4'b0000) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_status got=%b exp=none", st);
                end else begin
                    e = exp_q.pop_front();
                    if (st !== e.st || d_out !== e.dout) begin
                        bad++;
                        $display("FAIL sb_status got=%b/%0h exp=%b/%0h", st, d_out, e.st, e.dout);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1) reset held two cycles with a write request
        reset_n = 1'b0;
        wr_en   = 1'b1;
        d_in    = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        wr_en = 1'b0;
        chk("rst_count", 32'(data_count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", d_out, 32'h0);
        chk("rst_status", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);
        reset_n = 1'b1;
        mon_on  = 1'b1;

        // 2/3) fill, overflow, drain in order, underflow
        for (int i = 1; i <= 8; i++) begin
            do_write(32'(i), ST_WACK);
            chk("fill_count", 32'(data_count), 32'(i));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_empty", 32'(empty), 32'd0);
        do_write(32'd9, ST_WERR);
        chk("ovf_count", 32'(data_count), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            do_read(32'(i), ST_RACK);
            chk("drain_count", 32'(data_count), 32'(8 - i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_full", 32'(full), 32'd0);
        do_read(32'h0, ST_RERR);
        chk("udf_count", 32'(data_count), 32'd0);
        chk("udf_dout_hold", d_out, 32'd8);

        // 4) wrap: 6 in/out then 5 across the pointer wrap
        for (int i = 0; i < 6; i++) do_write(32'h10 + 32'(i), ST_WACK);
        for (int i = 0; i < 6; i++) do_read(32'h10 + 32'(i), ST_RACK);
        for (int i = 0; i < 5; i++) do_write(32'hA0 + 32'(i), ST_WACK);
        chk("wrap_count", 32'(data_count), 32'd5);
        for (int i = 0; i < 5; i++) do_read(32'hA0 + 32'(i), ST_RACK);
        chk("wrap_empty", 32'(empty), 32'd1);

        // 5) simultaneous requests with three entries stored
        for (int i = 0; i < 3; i++) do_write(32'hB0 + 32'(i), ST_WACK);
        step(1'b1, 1'b1, 32'h77);
        chk("sim_count", 32'(data_count), 32'd3);
        chk("sim_status", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);
        chk("sim_dout", d_out, 32'hA4);

        // 6) mid-operation reset at count 5, overriding a read request
        do_write(32'hB3, ST_WACK);
        do_write(32'hB4, ST_WACK);
        chk("pre_rst_count", 32'(data_count), 32'd5);
        reset_n = 1'b0;
        step(1'b0, 1'b1, 32'h0);
        reset_n = 1'b1;
        chk("mid_rst_count", 32'(data_count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_dout", d_out, 32'h0);
        chk("mid_rst_status", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);
        last_rd = 32'h0;
        do_read(32'h0, ST_RERR);
        do_write(32'hC5, ST_WACK);
        do_read(32'hC5, ST_RACK);
        chk("post_rst_empty", 32'(empty), 32'd1);

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
